// File: rtl/filter_preloader_pkg.sv
// Shared types and constants for the filter preloader: FSM states, retry default
// and the fixed Wishbone cycle attributes.
package filter_preloader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int         MAX_RETRY_DEF = 3;

    localparam logic [3:0] SEL_ALL     = 4'b1111;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/filter_buf_ram.sv
// Simple dual-port filter buffer: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module filter_buf_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/filter_preloader.sv
// Loads int8 filter taps from memory over Wishbone into a local buffer and serves
// single-word reads to the convolution CFU once the load is over.
//
// state  | meaning
// IDLE   | waiting for start; buffer readable
// FETCH  | bus cycle open, one word requested per ack; retries on bus error
// FINISH | last word stored, done pulses, back to IDLE next cycle
module filter_preloader
    import filter_preloader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8,
    parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [15:0]      num_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      words_loaded,
    output logic [29:0]      cfu_ram_adr,
    output logic             cfu_ram_cyc,
    output logic             cfu_ram_stb,
    output logic             cfu_ram_we,
    output logic [3:0]       cfu_ram_sel,
    output logic [2:0]       cfu_ram_cti,
    output logic [1:0]       cfu_ram_bte,
    input  logic [31:0]      cfu_ram_dat_miso,
    input  logic             cfu_ram_ack,
    input  logic             cfu_ram_err,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    output logic             rd_valid
);

    localparam int                 RETRY_W    = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [15:0]        DEPTH_16   = 16'(DEPTH_WORDS);

    state_t             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        words_q, words_d;
    logic [29:0]        cur_adr_q, cur_adr_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               gap_q, gap_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rd_valid_q, rd_valid_d;
    logic               hit_q, hit_d;
    logic               ram_we, ram_re, stb;
    logic [31:0]        ram_rdata;
    logic               unused_adr_bits;

    assign unused_adr_bits = ^base_adr[1:0];

    // stb is withheld for one cycle after a bus error before the word is re-issued
    assign stb = (state_q == FETCH) && !gap_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        words_d    = words_q;
        cur_adr_d  = cur_adr_q;
        retry_d    = retry_q;
        gap_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        ram_we     = 1'b0;
        rd_valid_d = rd_en && (state_q != FETCH);
        ram_re     = rd_valid_d;
        hit_d      = hit_q;
        if (ram_re) hit_d = (16'(rd_idx) < words_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d     = 1'b0;
                    retry_d   = '0;
                    words_d   = '0;
                    len_d     = (num_words > DEPTH_16) ? DEPTH_16 : num_words;
                    cur_adr_d = base_adr[31:2];
                    if (num_words == 16'd0) done_d  = 1'b1;
                    else                    state_d = FETCH;
                end
            end
            FETCH: begin
                // ack wins over a simultaneous err
                if (stb && cfu_ram_ack) begin
                    ram_we    = 1'b1;
                    words_d   = words_q + 16'd1;
                    cur_adr_d = cur_adr_q + 30'd1;
                    retry_d   = '0;
                    if (words_q + 16'd1 == len_q) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end else if (stb && cfu_ram_err) begin
                    if (retry_q == RETRY_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = 1'b1;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            words_q    <= '0;
            cur_adr_q  <= '0;
            retry_q    <= '0;
            gap_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            words_q    <= words_d;
            cur_adr_q  <= cur_adr_d;
            retry_q    <= retry_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            hit_q      <= hit_d;
        end
    end

    filter_buf_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (IDX_W),
        .DW    (32)
    ) u_buf (
        .clk   (clk),
        .we    (ram_we),
        .waddr (words_q[IDX_W-1:0]),
        .wdata (cfu_ram_dat_miso),
        .re    (ram_re),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    assign busy         = (state_q == FETCH);
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;
    assign cfu_ram_adr  = cur_adr_q;
    assign cfu_ram_cyc  = (state_q == FETCH);
    assign cfu_ram_stb  = stb;
    assign cfu_ram_we   = 1'b0;
    assign cfu_ram_sel  = SEL_ALL;
    assign cfu_ram_cti  = CTI_CLASSIC;
    assign cfu_ram_bte  = BTE_LINEAR;
    assign rd_valid     = rd_valid_q;
    // out-of-range reads return zero; the flag only moves on an accepted read
    assign rd_data      = hit_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_filter_preloader.sv
// Bench for filter_preloader: zero-wait Wishbone slave with error injection,
// scoreboards for bus addresses and buffer reads.
module tb_filter_preloader;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] base_adr;
    logic [15:0] num_words;
    logic        busy, done, err;
    logic [15:0] words_loaded;
    logic [29:0] cfu_ram_adr;
    logic        cfu_ram_cyc, cfu_ram_stb, cfu_ram_we;
    logic [3:0]  cfu_ram_sel;
    logic [2:0]  cfu_ram_cti;
    logic [1:0]  cfu_ram_bte;
    logic [31:0] cfu_ram_dat_miso;
    logic        cfu_ram_ack, cfu_ram_err;
    logic        rd_en;
    logic [7:0]  rd_idx;
    logic [31:0] rd_data;
    logic        rd_valid;

    int n_tests, n_fail;
    int cycle_no, start_cyc;
    int ack_cnt, first_ack_tick, last_ack_tick, done_cnt, done_tick;
    int cyc_seen, err_issues, gap_cnt, err_left;
    logic [29:0] err_adr;
    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_rd_q[$];

    filter_preloader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_adr         (base_adr),
        .num_words        (num_words),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .words_loaded     (words_loaded),
        .cfu_ram_adr      (cfu_ram_adr),
        .cfu_ram_cyc      (cfu_ram_cyc),
        .cfu_ram_stb      (cfu_ram_stb),
        .cfu_ram_we       (cfu_ram_we),
        .cfu_ram_sel      (cfu_ram_sel),
        .cfu_ram_cti      (cfu_ram_cti),
        .cfu_ram_bte      (cfu_ram_bte),
        .cfu_ram_dat_miso (cfu_ram_dat_miso),
        .cfu_ram_ack      (cfu_ram_ack),
        .cfu_ram_err      (cfu_ram_err),
        .rd_en            (rd_en),
        .rd_idx           (rd_idx),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [29:0] a);
        logic [31:0] v;
        if (a == 30'h402) v = 32'h03FE_7F80;
        else              v = {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
        return v;
    endfunction

    task automatic clr_stats();
        ack_cnt = 0; first_ack_tick = -1; last_ack_tick = -1;
        done_cnt = 0; done_tick = -1; cyc_seen = 0; err_issues = 0; gap_cnt = 0;
    endtask

    // one clock: observe outputs after the edge, then answer as a zero-wait slave
    task automatic tick();
        logic [31:0] e;
        @(posedge clk); #1;
        cycle_no++;
        cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0; cfu_ram_dat_miso = 32'h0;
        if (cfu_ram_cyc) cyc_seen++;
        if (cfu_ram_cyc && !cfu_ram_stb) gap_cnt++;
        if (done) begin done_cnt++; done_tick = cycle_no; end
        if (cfu_ram_cyc && cfu_ram_stb) begin
            if (err_left > 0 && cfu_ram_adr == err_adr) begin
                cfu_ram_err = 1'b1; err_left--; err_issues++;
            end else begin
                cfu_ram_ack = 1'b1;
                cfu_ram_dat_miso = slave_data(cfu_ram_adr);
                if (ack_cnt == 0) first_ack_tick = cycle_no;
                last_ack_tick = cycle_no;
                ack_cnt++;
                if (exp_adr_q.size() == 0) chk("adr_extra", 32'(cfu_ram_stb), 32'd0);
                else begin
                    e = exp_adr_q.pop_front();
                    chk("bus_adr", {2'b00, cfu_ram_adr}, e);
                end
            end
        end
        if (rd_valid) begin
            if (exp_rd_q.size() == 0) chk("rd_extra", 32'(rd_valid), 32'd0);
            else begin
                e = exp_rd_q.pop_front();
                chk("rd_data", rd_data, e);
            end
        end
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] n, input int n_acks);
        clr_stats();
        for (int i = 0; i < n_acks; i++) exp_adr_q.push_back({2'b00, base[31:2] + 30'(i)});
        start = 1'b1; base_adr = base; num_words = n;
        start_cyc = cycle_no;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int max_cycles);
        int k = 0;
        while (cfu_ram_cyc && k < max_cycles) begin tick(); k++; end
        chk("load_timeout", 32'(cfu_ram_cyc), 32'd0);
        tick();
    endtask

    task automatic do_read(input logic [7:0] idx, input logic [31:0] exp, input bit accept);
        rd_en = 1'b1; rd_idx = idx;
        if (accept) exp_rd_q.push_back(exp);
        tick();
        if (accept) chk("rd_valid", 32'(rd_valid), 32'd1);
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cycle_no = 0; start_cyc = 0;
        reset = 1'b1; start = 1'b0; base_adr = 32'h0; num_words = 16'h0;
        cfu_ram_dat_miso = 32'h0; cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0;
        rd_en = 1'b0; rd_idx = 8'h0; err_left = 0; err_adr = 30'h0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_cyc_stb", {30'd0, cfu_ram_cyc, cfu_ram_stb}, 32'd0);
        chk("rst_rd", {31'd0, rd_valid} | rd_data, 32'd0);
        chk("wb_const", {22'd0, cfu_ram_we, cfu_ram_sel, cfu_ram_cti, cfu_ram_bte}, {22'd0, 1'b0, 4'b1111, 3'b000, 2'b00});
        reset = 1'b0;
        tick();

        // four words from 0x1000, zero-wait slave
        do_start(32'h0000_1000, 16'd4, 4);
        run_to_idle(20);
        chk("l4_first_adr_lat", 32'(first_ack_tick - start_cyc), 32'd1);
        chk("l4_last_ack", 32'(last_ack_tick - start_cyc), 32'd4);
        chk("l4_done_cycle", 32'(done_tick - start_cyc), 32'd5);
        chk("l4_done_cnt", 32'(done_cnt), 32'd1);
        chk("l4_words", 32'(words_loaded), 32'd4);
        chk("l4_err", 32'(err), 32'd0);

        do_read(8'd2, 32'h03FE_7F80, 1'b1);
        do_read(8'd5, 32'h0, 1'b1);
        do_read(8'd0, slave_data(30'h400), 1'b1);
        do_read(8'd3, slave_data(30'h403), 1'b1);

        // eight words; a second start and a read during FETCH must be ignored
        do_start(32'h0000_2000, 16'd8, 8);
        tick();
        start = 1'b1; base_adr = 32'h0000_9000; num_words = 16'd2;
        tick();
        start = 1'b0;
        do_read(8'd0, 32'h0, 1'b0);
        chk("busy_rd_valid", 32'(rd_valid), 32'd0);
        chk("busy_rd_hold", rd_data, slave_data(30'h403));
        run_to_idle(40);
        chk("l8_acks", 32'(ack_cnt), 32'd8);
        chk("l8_words", 32'(words_loaded), 32'd8);
        chk("l8_done_cnt", 32'(done_cnt), 32'd1);
        do_read(8'd7, slave_data(30'h807), 1'b1);
        do_read(8'd8, 32'h0, 1'b1);

        // request beyond the buffer depth is clamped
        do_start(32'h0, 16'd300, 256);
        run_to_idle(400);
        chk("big_acks", 32'(ack_cnt), 32'd256);
        chk("big_words", 32'(words_loaded), 32'd256);
        chk("big_done_cnt", 32'(done_cnt), 32'd1);
        do_read(8'd255, slave_data(30'd255), 1'b1);

        // two errors on word 1, then success
        err_adr = 30'hC01; err_left = 2;
        do_start(32'h0000_3000, 16'd3, 3);
        run_to_idle(30);
        chk("retry_err_issues", 32'(err_issues), 32'd2);
        chk("retry_stb_gaps", 32'(gap_cnt), 32'd2);
        chk("retry_done_cycle", 32'(done_tick - start_cyc), 32'd8);
        chk("retry_err", 32'(err), 32'd0);
        chk("retry_words", 32'(words_loaded), 32'd3);

        // three errors on word 1 aborts the load
        err_adr = 30'hC01; err_left = 3;
        do_start(32'h0000_3000, 16'd3, 1);
        run_to_idle(30);
        err_left = 0;
        chk("abort_err_issues", 32'(err_issues), 32'd3);
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_words", 32'(words_loaded), 32'd1);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        do_read(8'd0, slave_data(30'hC00), 1'b1);
        do_read(8'd1, 32'h0, 1'b1);

        // zero-length load
        do_start(32'h0000_7000, 16'd0, 0);
        chk("zero_done_next", 32'(done_tick - start_cyc), 32'd1);
        chk("zero_err_cleared", 32'(err), 32'd0);
        repeat (3) tick();
        chk("zero_no_cyc", 32'(cyc_seen), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);
        chk("zero_words", 32'(words_loaded), 32'd0);

        // reset in the middle of a load
        do_start(32'h0000_5000, 16'd50, 5);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_cyc_stb", {30'd0, cfu_ram_cyc, cfu_ram_stb}, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_words", 32'(words_loaded), 32'd0);
        chk("mid_rst_rd_data", rd_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ack_ignored", 32'(words_loaded), 32'd0);
        chk("post_rst_cyc", 32'(cfu_ram_cyc), 32'd0);
        cfu_ram_ack = 1'b0;
        tick();

        chk("adr_q_drained", 32'(exp_adr_q.size()), 32'd0);
        chk("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
